// File: rtl/instr_fetch_pipe.sv
// Instruction-fetch stage: synchronous imem requests, 2-entry output buffer
// toward decode with valid/ready back-pressure, and a flushing redirect port.
module instr_fetch_pipe #(
    parameter int unsigned             ADDR_W   = 8,
    parameter int unsigned             INSTR_W  = 32,
    parameter int unsigned             PC_STEP  = 1,
    parameter logic [ADDR_W-1:0]       RESET_PC = '0
) (
    input  logic               clock,
    input  logic               rst,
    input  logic               redirect_en,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               imem_en,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               id_valid,
    input  logic               id_ready,
    output logic [INSTR_W-1:0] id_instr,
    output logic [ADDR_W-1:0]  id_pc,
    output logic [ADDR_W-1:0]  id_npc
);

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               inflight_q, inflight_d;
    logic [ADDR_W-1:0]  inflight_pc_q;
    logic [1:0]         count_q, count_d;
    logic [INSTR_W-1:0] buf_instr_q [2];
    logic [INSTR_W-1:0] buf_instr_d [2];
    logic [ADDR_W-1:0]  buf_pc_q [2];
    logic [ADDR_W-1:0]  buf_pc_d [2];

    logic               xfer;
    logic               issue;
    logic [2:0]         occ;
    logic [1:0]         base;

    assign id_valid  = (count_q != 2'd0);
    assign xfer      = id_valid && id_ready;
    // Occupancy after this cycle's pop, including the response still in flight.
    assign occ       = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, xfer};
    assign issue     = rst && !redirect_en && (occ < 3'd2);
    assign base      = count_q - {1'b0, xfer};

    assign imem_en   = issue;
    assign imem_addr = pc_q;

    assign id_instr  = id_valid ? buf_instr_q[0]        : '0;
    assign id_pc     = id_valid ? buf_pc_q[0]           : '0;
    assign id_npc    = id_valid ? (buf_pc_q[0] + STEP)  : '0;

    always_comb begin
        pc_d        = pc_q;
        inflight_d  = issue;
        count_d     = count_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;

        if (issue) begin
            pc_d = pc_q + STEP;
        end

        if (redirect_en) begin
            pc_d       = redirect_pc;
            count_d    = 2'd0;
            inflight_d = 1'b0;
        end else begin
            if (xfer) begin
                buf_instr_d[0] = buf_instr_q[1];
                buf_pc_d[0]    = buf_pc_q[1];
            end
            if (inflight_q) begin
                buf_instr_d[base[0]] = imem_rdata;
                buf_pc_d[base[0]]    = inflight_pc_q;
            end
            count_d = base + {1'b0, inflight_q};
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            count_q       <= 2'd0;
            for (int unsigned i = 0; i < 2; i++) begin
                buf_instr_q[i] <= '0;
                buf_pc_q[i]    <= '0;
            end
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            if (issue) begin
                inflight_pc_q <= pc_q;
            end
            for (int unsigned i = 0; i < 2; i++) begin
                buf_instr_q[i] <= buf_instr_d[i];
                buf_pc_q[i]    <= buf_pc_d[i];
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_pipe.sv
// Bench for instr_fetch_pipe: expected fetch stream modelled as consecutive
// addresses restarted by redirects/reset, plus directed latency and hold checks.
module tb_instr_fetch_pipe;

    logic        clock = 1'b0;
    logic        rst;
    logic        redirect_en;
    logic [7:0]  redirect_pc;
    logic        imem_en;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [7:0]  id_pc;
    logic [7:0]  id_npc;

    int checks = 0;
    int errors = 0;

    logic [7:0]  exp_pc;
    bit          stall_prev;
    logic [7:0]  prev_pc;
    logic [31:0] prev_instr;
    logic        s_valid, s_en;
    logic [7:0]  s_pc, s_npc;

    instr_fetch_pipe #(
        .ADDR_W  (8),
        .INSTR_W (32),
        .PC_STEP (1),
        .RESET_PC(8'h00)
    ) dut (
        .clock      (clock),
        .rst        (rst),
        .redirect_en(redirect_en),
        .redirect_pc(redirect_pc),
        .imem_en    (imem_en),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .id_valid   (id_valid),
        .id_ready   (id_ready),
        .id_instr   (id_instr),
        .id_pc      (id_pc),
        .id_npc     (id_npc)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [7:0] a);
        return 32'hA000_0000 | {24'h0, a};
    endfunction

    // Synchronous BRAM: data one cycle after the request, garbage otherwise.
    always @(posedge clock) imem_rdata <= imem_en ? mem_word(imem_addr) : $urandom();

    // One clock cycle: drive, sample, check against the stream model.
    task automatic cycle(input bit rdy, input bit redir, input logic [7:0] rpc);
        logic [7:0] nxt;
        @(negedge clock);
        id_ready = rdy; redirect_en = redir; redirect_pc = rpc;
        #1;
        s_valid = id_valid; s_en = imem_en; s_pc = id_pc; s_npc = id_npc;
        if (stall_prev) begin
            checks++;
            if (id_valid !== 1'b1 || id_pc !== prev_pc || id_instr !== prev_instr) begin
                errors++;
                $display("FAIL hold: valid=%b pc=%h instr=%h required valid=1 pc=%h instr=%h",
                         id_valid, id_pc, id_instr, prev_pc, prev_instr);
            end
        end
        if (id_valid === 1'b1) begin
            nxt = exp_pc + 8'd1;
            checks++;
            if (id_pc !== exp_pc || id_instr !== mem_word(exp_pc) || id_npc !== nxt) begin
                errors++;
                $display("FAIL stream: pc=%h instr=%h npc=%h required pc=%h instr=%h npc=%h",
                         id_pc, id_instr, id_npc, exp_pc, mem_word(exp_pc), nxt);
            end
            if (rdy) exp_pc = nxt;
        end
        stall_prev = id_valid && !rdy && !redir;
        prev_pc    = id_pc;
        prev_instr = id_instr;
        if (redir) exp_pc = rpc;
        @(posedge clock);
        #1;
    endtask

    task automatic check_in_reset(input string name);
        checks++;
        if (id_valid !== 1'b0 || id_instr !== 32'h0 || id_pc !== 8'h0 ||
            id_npc !== 8'h0 || imem_en !== 1'b0) begin
            errors++;
            $display("FAIL %s: valid=%b instr=%h pc=%h npc=%h en=%b required all zero",
                     name, id_valid, id_instr, id_pc, id_npc, imem_en);
        end
    endtask

    // Release reset mid-cycle and verify the 2-cycle first-fetch latency.
    task automatic release_and_check_latency(input string name);
        stall_prev = 0;
        exp_pc = 8'h00;
        @(posedge clock);
        #2 rst = 1'b1;
        cycle(1, 0, 8'h00);
        checks++;
        if (s_en !== 1'b1 || s_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_c0: en=%b valid=%b required en=1 valid=0", name, s_en, s_valid);
        end
        cycle(1, 0, 8'h00);
        checks++;
        if (s_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_c1: valid=%b required 0", name, s_valid);
        end
        cycle(1, 0, 8'h00);
        checks++;
        if (s_valid !== 1'b1 || s_pc !== 8'h00) begin
            errors++;
            $display("FAIL %s_c2: valid=%b pc=%h required valid=1 pc=00", name, s_valid, s_pc);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; id_ready = 1'b1; redirect_en = 1'b0; redirect_pc = 8'h00;
        exp_pc = 8'h00; stall_prev = 0;
        repeat (2) @(posedge clock);
        #1 check_in_reset("reset_state");
        release_and_check_latency("reset_release");
    endtask

    task automatic test_stream();
        for (int i = 0; i < 12; i++) begin
            cycle(1, 0, 8'h00);
            checks++;
            if (s_valid !== 1'b1) begin
                errors++;
                $display("FAIL stream_gap: cycle %0d valid=%b required 1", i, s_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, 8'h00);
            if (i >= 1) begin
                checks++;
                if (s_en !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_en: stall cycle %0d en=%b required 0", i, s_en);
                end
            end
        end
        for (int i = 0; i < 6; i++) begin
            cycle(1, 0, 8'h00);
            checks++;
            if (s_valid !== 1'b1) begin
                errors++;
                $display("FAIL resume_gap: cycle %0d valid=%b required 1", i, s_valid);
            end
        end
    endtask

    task automatic test_redirect_flush();
        cycle(0, 1, 8'h40);
        for (int i = 1; i <= 3; i++) begin
            cycle(1, 0, 8'h00);
            checks++;
            if (i < 3 && s_valid !== 1'b0) begin
                errors++;
                $display("FAIL redir_bubble: r+%0d valid=%b required 0", i, s_valid);
            end else if (i == 3 && (s_valid !== 1'b1 || s_pc !== 8'h40 || s_npc !== 8'h41)) begin
                errors++;
                $display("FAIL redir_target: valid=%b pc=%h npc=%h required 1 40 41",
                         s_valid, s_pc, s_npc);
            end
        end
        repeat (4) cycle(1, 0, 8'h00);
    endtask

    task automatic test_redirect_handshake();
        bit found = 0;
        cycle(1, 1, 8'h02);
        for (int i = 0; i < 20 && !found; i++) begin
            if (id_valid === 1'b1 && id_pc === 8'h05) found = 1;
            else cycle(1, 0, 8'h00);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL hs_reach: pc=%h required 05 within 20 cycles", id_pc);
        end
        cycle(1, 1, 8'h20);
        found = 0;
        for (int i = 0; i < 6 && !found; i++) begin
            cycle(1, 0, 8'h00);
            if (s_valid === 1'b1) found = 1;
        end
        checks++;
        if (!found || s_pc !== 8'h20) begin
            errors++;
            $display("FAIL hs_next: found=%0d pc=%h required 1 20", found, s_pc);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] seq [4];
        logic [7:0] npc_ff;
        int n = 0;
        npc_ff = 8'hAA;
        cycle(1, 1, 8'hFE);
        for (int i = 0; i < 12 && n < 4; i++) begin
            cycle(1, 0, 8'h00);
            if (s_valid === 1'b1) begin
                seq[n] = s_pc;
                if (s_pc === 8'hFF) npc_ff = s_npc;
                n++;
            end
        end
        checks++;
        if (n != 4 || seq[0] !== 8'hFE || seq[1] !== 8'hFF || seq[2] !== 8'h00 || seq[3] !== 8'h01) begin
            errors++;
            $display("FAIL wrap_seq: n=%0d seq=%h %h %h %h required FE FF 00 01",
                     n, seq[0], seq[1], seq[2], seq[3]);
        end
        checks++;
        if (npc_ff !== 8'h00) begin
            errors++;
            $display("FAIL wrap_npc: npc at FF=%h required 00", npc_ff);
        end
    endtask

    task automatic test_reset_midstream();
        repeat (3) cycle(0, 0, 8'h00);
        @(negedge clock);
        #2 rst = 1'b0;
        #1 check_in_reset("reset_async");
        id_ready = 1'b1;
        @(posedge clock);
        #1 check_in_reset("reset_held");
        release_and_check_latency("reset_mid");
        repeat (6) cycle(1, 0, 8'h00);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, 8'($urandom()));
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_flush();
        test_redirect_handshake();
        test_wrap();
        test_reset_midstream();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_pipe.md
Name: instr_fetch_pipe

Overview:
Parametrised instruction-fetch stage for the KGP RISC pipeline. It supersedes the fixed 8-bit PC / 32-bit fetch with a configurable-width PC and a synchronous instruction-memory request interface. It adds a valid/ready handshake toward decode, a 2-entry output buffer for back-pressure, and a redirect (branch/jump) port that flushes wrong-path fetches. It sits between the instruction BRAM and the IF/ID consumer.

Parameters:
ADDR_W, 8, PC and instruction-memory address width.
INSTR_W, 32, instruction word width.
PC_STEP, 1, PC increment per sequential fetch, in address units.
RESET_PC, 0, PC value loaded at reset, ADDR_W bits.

Ports:
clock  in  1  single pipeline clock; all state updates on the rising edge.
rst  in  1  reset, asynchronous, active-low.
redirect_en  in  1  load redirect_pc and flush all younger fetches.
redirect_pc  in  ADDR_W  redirect target.
imem_en  out  1  read request to instruction memory this cycle.
imem_addr  out  ADDR_W  read address, equal to the PC register.
imem_rdata  in  INSTR_W  read data, valid exactly 1 cycle after imem_en.
id_valid  out  1  id_instr, id_pc and id_npc hold a valid fetched instruction.
id_ready  in  1  decode accepts the instruction this cycle.
id_instr  out  INSTR_W  fetched instruction.
id_pc  out  ADDR_W  address of id_instr.
id_npc  out  ADDR_W  id_pc + PC_STEP, modulo 2^ADDR_W.

Behaviour:
- Reset (rst=0, async):
  - pc=RESET_PC; in-flight flag=0; buffer count=0.
  - id_valid=0; id_instr=0; id_pc=0; id_npc=0.
  - imem_en=0 while rst=0.
- State:
  - pc register.
  - inflight (1 bit): a request was issued last cycle.
  - inflight_pc: the address of that request.
  - 2-entry FIFO buffer (instr, pc) with count 0..2.
  - The buffer head drives the id_* outputs. id_npc is computed from the head pc.
- Transfer: a handshake occurs when id_valid && id_ready. id_valid = (count != 0).
- Issue rule: imem_en = rst && !redirect_en && (count + inflight - xfer) < 2, where xfer = id_valid && id_ready. A returning response can therefore never overflow the buffer.
- On issue: pc <= pc + PC_STEP, wrapping modulo 2^ADDR_W with no flag. inflight <= 1 and inflight_pc <= pc. Otherwise inflight <= 0.
- Response: if inflight=1 and there is no redirect this cycle, imem_rdata and inflight_pc are written to the buffer tail at the edge.
- Latency:
  - A request issued in cycle n gives id_valid in cycle n+2.
  - With id_ready held high, throughput is 1 instruction per cycle after fill.
- Back-pressure:
  - While id_ready=0, id_* outputs stay stable and id_valid stays high.
  - At most 2 instructions are buffered.
  - Fetch resumes without loss or duplication when id_ready returns.
- Redirect (redirect_en=1 in cycle r):
  - A transfer occurring in cycle r still completes; decode owns that instruction.
  - All other buffer entries are discarded and the in-flight response is dropped. count <= 0 and inflight <= 0.
  - pc <= redirect_pc; no request is issued in cycle r.
  - The target is fetched in cycle r+1 and presented with id_valid=1 in cycle r+3.
  - Back-to-back redirects: the last one wins, and each one restarts the penalty.
- Reset mid-operation: all state clears immediately and asynchronously. Any imem_rdata arriving after reset release is ignored because inflight=0.
- Boundary: when pc=2^ADDR_W-PC_STEP, the next fetch address wraps to 0. id_npc wraps identically.

Test Plan:
- Reset release, RESET_PC=0, id_ready=1, memory word = 0xA000_0000+addr -> imem_en high from the first cycle. id_valid rises 2 cycles later. Stream is addr 0,1,2,... with id_npc = id_pc+1 and no gaps.
- Stream running, id_ready=0 for 5 cycles -> exactly 2 entries buffered and id_* held constant. imem_en drops after the buffer fills. After release, sequence continues without skip or repeat.
- redirect_en with redirect_pc=0x40 while a request is in flight and the buffer is full -> old entries never appear. id_valid=0 for cycles r+1 and r+2. In cycle r+3, id_pc=0x40, id_instr=mem[0x40], id_npc=0x41.
- Redirect in the same cycle as a handshake of pc=0x05 -> 0x05 counts as consumed and the next instruction presented is from the target.
- redirect_pc=0xFE, ADDR_W=8 -> id_pc sequence is 0xFE, 0xFF, 0x00, 0x01. At id_pc=0xFF, id_npc=0x00.
- rst pulsed low mid-stream with the buffer full -> id_valid=0 and id_* zero immediately, without waiting for a clock edge. After release, fetch restarts at RESET_PC with 2-cycle latency and no stale data.
